// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: CSR addresses, mcause codes and sequencer states shared by trap_ctrl and trap_cause_enc
package trap_ctrl_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL = 12'h343;
  localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK = 5'd3;
  localparam logic [4:0] CAUSE_ECALL = 5'd11;
  localparam logic [4:0] CAUSE_IRQ_SOFT = 5'd3;
  localparam logic [4:0] CAUSE_IRQ_TIMER = 5'd7;
  localparam logic [4:0] CAUSE_IRQ_EXT = 5'd11;
  typedef enum logic [2:0] {IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, JUMP, W_MRET, MRET_JUMP} state_t;
endpackage

// File: rtl/trap_cause_enc.sv
// trap_cause_enc: prioritises exceptions, mret and enabled interrupts into take/cause/tval
module trap_cause_enc
  import trap_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          illegal,
  input  logic          ebreak,
  input  logic          ecall,
  input  logic          mret,
  input  logic          ex_trap,
  input  logic          soft_trap,
  input  logic          tcmp_trap,
  input  logic          mie,
  input  logic [DW-1:0] inst,
  output logic          take,
  output logic          is_mret,
  output logic [DW-1:0] cause,
  output logic [DW-1:0] tval
);
  logic exc;
  logic irq;
  logic [4:0] code;
  assign exc = illegal | ebreak | ecall;
  assign irq = mie & (ex_trap | soft_trap | tcmp_trap);
  assign is_mret = !exc & mret;
  assign take = exc | mret | irq;
  assign code = illegal ? CAUSE_ILLEGAL : ebreak ? CAUSE_EBREAK : ecall ? CAUSE_ECALL :
                ex_trap ? CAUSE_IRQ_EXT : soft_trap ? CAUSE_IRQ_SOFT : CAUSE_IRQ_TIMER;
  assign cause = {!exc, {(DW-6){1'b0}}, code};
  assign tval = illegal ? inst : '0;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/mret sequencer on the CSR trap channel; define TRAP_VECTORED_EN for vectored interrupt targets
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int DW = 32,
  parameter int CAW = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inst_valid_i,
  input  logic [DW-1:0]  inst_addr_i,
  input  logic [DW-1:0]  inst_i,
  input  logic           ecall_i,
  input  logic           ebreak_i,
  input  logic           illegal_i,
  input  logic           mret_i,
  input  logic           ex_trap_i,
  input  logic           soft_trap_i,
  input  logic           tcmp_trap_i,
  input  logic           mstatus_MIE3_i,
  input  logic [DW-1:0]  mepc_i,
  input  logic           idex_csr_we_i,
  output logic           trap_csr_we_o,
  output logic [CAW-1:0] trap_csr_addr_o,
  output logic [DW-1:0]  trap_csr_wdata_o,
  input  logic [DW-1:0]  trap_csr_rdata_i,
  output logic           hold_o,
  output logic           jump_o,
  output logic [DW-1:0]  jump_addr_o
);
  state_t state;
  logic [DW-1:0] epc, cause_q, tval_q, enc_cause, enc_tval, rd, base, vec;
  logic enc_take, enc_mret, go;
  trap_cause_enc #(.DW(DW)) u_enc (
    .illegal(illegal_i),
    .ebreak(ebreak_i),
    .ecall(ecall_i),
    .mret(mret_i),
    .ex_trap(ex_trap_i),
    .soft_trap(soft_trap_i),
    .tcmp_trap(tcmp_trap_i),
    .mie(mstatus_MIE3_i),
    .inst(inst_i),
    .take(enc_take),
    .is_mret(enc_mret),
    .cause(enc_cause),
    .tval(enc_tval)
  );
  assign go = inst_valid_i & enc_take;
  assign rd = trap_csr_rdata_i;
  assign base = {rd[DW-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign vec = (cause_q[DW-1] && rd[1:0] == 2'b01) ? base + DW'({cause_q[4:0], 2'b00}) : base;
`else
  assign vec = base;
`endif
  // write states hold while idex owns the CSR port, so the write is retried
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      epc <= '0;
      cause_q <= '0;
      tval_q <= '0;
    end else case (state)
      IDLE: if (go) begin
        epc <= inst_addr_i;
        cause_q <= enc_cause;
        tval_q <= enc_tval;
        state <= enc_mret ? W_MRET : W_MEPC;
      end
      W_MEPC: if (!idex_csr_we_i) state <= W_MCAUSE;
      W_MCAUSE: if (!idex_csr_we_i) state <= W_MTVAL;
      W_MTVAL: if (!idex_csr_we_i) state <= W_MSTATUS;
      W_MSTATUS: if (!idex_csr_we_i) state <= JUMP;
      W_MRET: if (!idex_csr_we_i) state <= MRET_JUMP;
      default: state <= IDLE;
    endcase
  always_comb begin
    trap_csr_addr_o = '0;
    trap_csr_wdata_o = '0;
    case (state)
      W_MEPC: begin
        trap_csr_addr_o = CAW'(CSR_MEPC);
        trap_csr_wdata_o = epc;
      end
      W_MCAUSE: begin
        trap_csr_addr_o = CAW'(CSR_MCAUSE);
        trap_csr_wdata_o = cause_q;
      end
      W_MTVAL: begin
        trap_csr_addr_o = CAW'(CSR_MTVAL);
        trap_csr_wdata_o = tval_q;
      end
      W_MSTATUS: begin
        trap_csr_addr_o = CAW'(CSR_MSTATUS);
        trap_csr_wdata_o = {rd[DW-1:8], rd[3], rd[6:4], 1'b0, rd[2:0]};
      end
      W_MRET: begin
        trap_csr_addr_o = CAW'(CSR_MSTATUS);
        trap_csr_wdata_o = {rd[DW-1:8], 1'b1, rd[6:4], rd[7], rd[2:0]};
      end
      JUMP: trap_csr_addr_o = CAW'(CSR_MTVEC);
      default: ;
    endcase
  end
  assign trap_csr_we_o = state inside {W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, W_MRET};
  assign hold_o = (state != IDLE) | go;
  assign jump_o = state inside {JUMP, MRET_JUMP};
  assign jump_addr_o = state == JUMP ? vec : state == MRET_JUMP ? mepc_i : '0;
endmodule
